ctrl_pipe_tracker: RTL and testbench

- Downstream consumer of the decoder's control buses (wb[2] = {RegWrite, MemtoReg}, mem[3] = {Branch, MemRead, MemWrite}, ex[7] = {Jump, ALUSrc, AluOp[3:0], RegDst}).
- Carries the buses and register numbers through three pipeline registers: ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards and raises a stall; inserts bubbles; applies branch flushes.
- Produces EX-stage forwarding selects.
- Sits between the ID stage and the EX/MEM/WB datapath of the 5-stage MIPS.

---
 rtl/ctrl_pipe_tracker.sv | 191 +++++++++++++++++++
 tb/tb_ctrl_pipe_tracker.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_tracker.sv
// ctrl_pipe_tracker: carries the decoder control buses and register numbers
// through the ID/EX, EX/MEM and MEM/WB registers of the 5-stage MIPS. It
// detects data hazards, inserts bubbles, applies branch flushes and produces
// the EX-stage operand forwarding selects.
//
// Build option CTRL_PIPE_FWD_EN:
//   defined   - forwarding selects active, only load-use hazards stall.
//   undefined - forwarding selects tied to 00; any RAW against ID/EX or
//               EX/MEM stalls until the writer reaches MEM/WB.
module ctrl_pipe_tracker #(
    parameter int NB_CTRL_EX = 7,
    parameter int NB_CTRL_M  = 3,
    parameter int NB_CTRL_WB = 2,
    parameter int NB_REG     = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  i_flush,
    input  logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus,
    input  logic [NB_CTRL_M-1:0]  i_ctrl_mem_bus,
    input  logic [NB_CTRL_EX-1:0] i_ctrl_exc_bus,
    input  logic [NB_REG-1:0]     i_rs,
    input  logic [NB_REG-1:0]     i_rt,
    input  logic [NB_REG-1:0]     i_rd,
    output logic                  o_stall,
    output logic [NB_CTRL_EX-1:0] o_ex_bus,
    output logic [NB_CTRL_M-1:0]  o_ex_mem_bus,
    output logic [NB_CTRL_WB-1:0] o_wb_bus,
    output logic [NB_REG-1:0]     o_ex_wreg,
    output logic [NB_REG-1:0]     o_mem_wreg,
    output logic [NB_REG-1:0]     o_wb_wreg,
    output logic [1:0]            o_fwd_a,
    output logic [1:0]            o_fwd_b
);

    // Control bit positions inside the decoder buses
    localparam int REGWRITE_BIT = NB_CTRL_WB - 1;  // wb  = {RegWrite, MemtoReg}
    localparam int MEMREAD_BIT  = 1;               // mem = {Branch, MemRead, MemWrite}
    localparam int REGDST_BIT   = 0;               // ex  = {..., RegDst}

    typedef enum logic [1:0] {
        ACT_HOLD,     // debug freeze: nothing moves
        ACT_SQUASH,   // ID/EX takes a bubble (flush or hazard), rest shift
        ACT_ADVANCE   // normal flow
    } stage_act_t;

    // ID/EX
    logic [NB_CTRL_WB-1:0] idex_wb;
    logic [NB_CTRL_M-1:0]  idex_mem;
    logic [NB_CTRL_EX-1:0] idex_ex;
    logic [NB_REG-1:0]     idex_rt;
    logic [NB_REG-1:0]     idex_wreg;
`ifdef CTRL_PIPE_FWD_EN
    logic [NB_REG-1:0]     idex_rs;
`endif
    // EX/MEM
    logic [NB_CTRL_WB-1:0] exmem_wb;
    logic [NB_CTRL_M-1:0]  exmem_mem;
    logic [NB_REG-1:0]     exmem_wreg;
    // MEM/WB
    logic [NB_CTRL_WB-1:0] memwb_wb;
    logic [NB_REG-1:0]     memwb_wreg;

    logic       load_use;
    logic       hazard;
    stage_act_t act;

    // Hazard detection against the instruction currently in ID
    always_comb begin
        load_use = idex_mem[MEMREAD_BIT] && (idex_rt != '0) &&
                   ((idex_rt == i_rs) || (idex_rt == i_rt));
`ifdef CTRL_PIPE_FWD_EN
        hazard = load_use;
`else
        hazard = load_use
               || (idex_wb[REGWRITE_BIT] && (idex_wreg != '0) &&
                   ((idex_wreg == i_rs) || (idex_wreg == i_rt)))
               || (exmem_wb[REGWRITE_BIT] && (exmem_wreg != '0) &&
                   ((exmem_wreg == i_rs) || (exmem_wreg == i_rt)));
`endif
    end

    // Edge action: freeze beats flush, flush and hazard both bubble ID/EX
    always_comb begin
        act     = ACT_ADVANCE;
        o_stall = 1'b0;
        if (!i_enable) begin
            act = ACT_HOLD;
        end else if (i_flush) begin
            act = ACT_SQUASH;
        end else if (hazard) begin
            act     = ACT_SQUASH;
            o_stall = 1'b1;
        end
    end

    // ID/EX register: captures decoder buses or a zero bubble
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idex_wb   <= '0;
            idex_mem  <= '0;
            idex_ex   <= '0;
            idex_rt   <= '0;
            idex_wreg <= '0;
`ifdef CTRL_PIPE_FWD_EN
            idex_rs   <= '0;
`endif
        end else begin
            case (act)
                ACT_SQUASH: begin
                    idex_wb   <= '0;
                    idex_mem  <= '0;
                    idex_ex   <= '0;
                    idex_rt   <= '0;
                    idex_wreg <= '0;
`ifdef CTRL_PIPE_FWD_EN
                    idex_rs   <= '0;
`endif
                end
                ACT_ADVANCE: begin
                    idex_wb   <= i_ctrl_wb_bus;
                    idex_mem  <= i_ctrl_mem_bus;
                    idex_ex   <= i_ctrl_exc_bus;
                    idex_rt   <= i_rt;
                    idex_wreg <= i_ctrl_exc_bus[REGDST_BIT] ? i_rd : i_rt;
`ifdef CTRL_PIPE_FWD_EN
                    idex_rs   <= i_rs;
`endif
                end
                default: ;
            endcase
        end
    end

    // EX/MEM and MEM/WB registers: shift whenever the pipe is not frozen
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            exmem_wb   <= '0;
            exmem_mem  <= '0;
            exmem_wreg <= '0;
            memwb_wb   <= '0;
            memwb_wreg <= '0;
        end else if (act != ACT_HOLD) begin
            exmem_wb   <= idex_wb;
            exmem_mem  <= idex_mem;
            exmem_wreg <= idex_wreg;
            memwb_wb   <= exmem_wb;
            memwb_wreg <= exmem_wreg;
        end
    end

`ifdef CTRL_PIPE_FWD_EN
    function automatic logic [1:0] fwd_sel(
        input logic [NB_REG-1:0] src,
        input logic              mem_we,
        input logic [NB_REG-1:0] mem_wreg,
        input logic              wb_we,
        input logic [NB_REG-1:0] wb_wreg
    );
        if (mem_we && (mem_wreg != '0) && (mem_wreg == src))
            return 2'b10;
        else if (wb_we && (wb_wreg != '0) && (wb_wreg == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Operand forwarding selects; EX/MEM (youngest) wins over MEM/WB
    always_comb begin
        o_fwd_a = fwd_sel(idex_rs, exmem_wb[REGWRITE_BIT], exmem_wreg,
                          memwb_wb[REGWRITE_BIT], memwb_wreg);
        o_fwd_b = fwd_sel(idex_rt, exmem_wb[REGWRITE_BIT], exmem_wreg,
                          memwb_wb[REGWRITE_BIT], memwb_wreg);
    end
`else
    // No forwarding path: operands always come from the register file
    always_comb begin
        o_fwd_a = 2'b00;
        o_fwd_b = 2'b00;
    end
`endif

    assign o_ex_bus     = idex_ex;
    assign o_ex_mem_bus = exmem_mem;
    assign o_wb_bus     = memwb_wb;
    assign o_ex_wreg    = idex_wreg;
    assign o_mem_wreg   = exmem_wreg;
    assign o_wb_wreg    = memwb_wreg;

endmodule

// File: tb/tb_ctrl_pipe_tracker.sv
// Table-driven bench for ctrl_pipe_tracker. Each row gives the ID-stage
// inputs for one cycle and the outputs expected before that cycle's edge.
// Expectations follow the CTRL_PIPE_FWD_EN build option.
module tb_ctrl_pipe_tracker;

    typedef struct packed {
        logic [1:0] wb;
        logic [2:0] mem;
        logic [6:0] ex;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } ins_t;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       flush;
        ins_t       ins;
        logic       stall;
        logic [6:0] ex;
        logic [2:0] mem;
        logic [1:0] wb;
        logic [4:0] ewr;
        logic [4:0] mwr;
        logic [4:0] wwr;
        logic [1:0] fa;
        logic [1:0] fb;
    } vec_t;

    logic       i_clk;
    logic       i_rst;
    logic       i_enable;
    logic       i_flush;
    logic [1:0] i_ctrl_wb_bus;
    logic [2:0] i_ctrl_mem_bus;
    logic [6:0] i_ctrl_exc_bus;
    logic [4:0] i_rs, i_rt, i_rd;
    logic       o_stall;
    logic [6:0] o_ex_bus;
    logic [2:0] o_ex_mem_bus;
    logic [1:0] o_wb_bus;
    logic [4:0] o_ex_wreg, o_mem_wreg, o_wb_wreg;
    logic [1:0] o_fwd_a, o_fwd_b;

    ctrl_pipe_tracker #(
        .NB_CTRL_EX(7),
        .NB_CTRL_M (3),
        .NB_CTRL_WB(2),
        .NB_REG    (5)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_enable      (i_enable),
        .i_flush       (i_flush),
        .i_ctrl_wb_bus (i_ctrl_wb_bus),
        .i_ctrl_mem_bus(i_ctrl_mem_bus),
        .i_ctrl_exc_bus(i_ctrl_exc_bus),
        .i_rs          (i_rs),
        .i_rt          (i_rt),
        .i_rd          (i_rd),
        .o_stall       (o_stall),
        .o_ex_bus      (o_ex_bus),
        .o_ex_mem_bus  (o_ex_mem_bus),
        .o_wb_bus      (o_wb_bus),
        .o_ex_wreg     (o_ex_wreg),
        .o_mem_wreg    (o_mem_wreg),
        .o_wb_wreg     (o_wb_wreg),
        .o_fwd_a       (o_fwd_a),
        .o_fwd_b       (o_fwd_b)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    vec_t vecs [64];
    int   n_rows;
    int   n_vec;
    int   n_miss;

    function automatic ins_t nop();
        return '0;
    endfunction

    function automatic ins_t addi(input logic [4:0] rt);
        ins_t r = '0;
        r.wb = 2'b10; r.ex = 7'b0100110; r.rt = rt;
        return r;
    endfunction

    function automatic ins_t lw(input logic [4:0] rs, input logic [4:0] rt);
        ins_t r = '0;
        r.wb = 2'b11; r.mem = 3'b010; r.ex = 7'b0100000; r.rs = rs; r.rt = rt;
        return r;
    endfunction

    function automatic ins_t sw(input logic [4:0] rs, input logic [4:0] rt);
        ins_t r = '0;
        r.mem = 3'b001; r.ex = 7'b0100000; r.rs = rs; r.rt = rt;
        return r;
    endfunction

    function automatic ins_t add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        ins_t r = '0;
        r.wb = 2'b10; r.ex = 7'b0000101; r.rs = rs; r.rt = rt; r.rd = rd;
        return r;
    endfunction

    task automatic row(input logic rst, input logic en, input logic fl, input ins_t ins,
                       input logic st, input logic [6:0] ex, input logic [2:0] mem,
                       input logic [1:0] wb, input logic [4:0] ewr, input logic [4:0] mwr,
                       input logic [4:0] wwr, input logic [1:0] fa, input logic [1:0] fb);
        vec_t v;
        v.rst = rst; v.en = en; v.flush = fl; v.ins = ins;
        v.stall = st; v.ex = ex; v.mem = mem; v.wb = wb;
        v.ewr = ewr; v.mwr = mwr; v.wwr = wwr; v.fa = fa; v.fb = fb;
        vecs[n_rows] = v;
        n_rows++;
    endtask

    task automatic drive(input logic rst, input logic en, input logic fl, input ins_t ins);
        i_rst          = rst;
        i_enable       = en;
        i_flush        = fl;
        i_ctrl_wb_bus  = ins.wb;
        i_ctrl_mem_bus = ins.mem;
        i_ctrl_exc_bus = ins.ex;
        i_rs           = ins.rs;
        i_rt           = ins.rt;
        i_rd           = ins.rd;
    endtask

    task automatic chk(input int idx, input string name, input logic [6:0] got, input logic [6:0] exp);
        if (got !== exp) begin
            $display("FAIL v%0d %s: got %0h expected %0h", idx, name, got, exp);
            n_miss++;
        end
    endtask

    initial begin
        int   stalls;
        logic done;
        int   exp_stalls;
        logic [1:0] exp_fa;

        n_rows = 0; n_vec = 0; n_miss = 0;

        // reset with nonzero inputs, then ADDI rt=8 flows to WB
        row(1,1,0, addi(8),     0, 7'h00,          3'b000, 2'b00,  0, 0, 0, 2'b00, 2'b00);
        row(1,1,0, addi(8),     0, 7'h00,          3'b000, 2'b00,  0, 0, 0, 2'b00, 2'b00);
        row(0,1,0, addi(8),     0, 7'h00,          3'b000, 2'b00,  0, 0, 0, 2'b00, 2'b00);
        row(0,1,0, nop(),       0, 7'b0100110,     3'b000, 2'b00,  8, 0, 0, 2'b00, 2'b00);
        row(0,1,0, nop(),       0, 7'h00,          3'b000, 2'b00,  0, 8, 0, 2'b00, 2'b00);
        row(0,1,0, nop(),       0, 7'h00,          3'b000, 2'b10,  0, 0, 8, 2'b00, 2'b00);
        // flush squashes SW in ID, older ADDI rt=7 continues
        row(0,1,0, addi(7),     0, 7'h00,          3'b000, 2'b00,  0, 0, 0, 2'b00, 2'b00);
        row(0,1,1, sw(2,6),     0, 7'b0100110,     3'b000, 2'b00,  7, 0, 0, 2'b00, 2'b00);
        row(0,1,0, nop(),       0, 7'h00,          3'b000, 2'b00,  0, 7, 0, 2'b00, 2'b00);
        row(0,1,0, nop(),       0, 7'h00,          3'b000, 2'b10,  0, 0, 7, 2'b00, 2'b00);
        // flush and load-use hazard in the same cycle
        row(0,1,0, lw(2,9),     0, 7'h00,          3'b000, 2'b00,  0, 0, 0, 2'b00, 2'b00);
        row(0,1,1, add(9,10,11),0, 7'b0100000,     3'b000, 2'b00,  9, 0, 0, 2'b00, 2'b00);
        row(0,1,0, nop(),       0, 7'h00,          3'b010, 2'b00,  0, 9, 0, 2'b00, 2'b00);
        row(0,1,0, nop(),       0, 7'h00,          3'b000, 2'b11,  0, 0, 9, 2'b00, 2'b00);
        // fill all stages, freeze 3 cycles, resume
        row(0,1,0, addi(8),     0, 7'h00,          3'b000, 2'b00,  0, 0, 0, 2'b00, 2'b00);
        row(0,1,0, lw(2,9),     0, 7'b0100110,     3'b000, 2'b00,  8, 0, 0, 2'b00, 2'b00);
        row(0,1,0, addi(7),     0, 7'b0100000,     3'b000, 2'b00,  9, 8, 0, 2'b00, 2'b00);
        row(0,0,0, add(7,9,11), 0, 7'b0100110,     3'b010, 2'b10,  7, 9, 8, 2'b00, 2'b00);
        row(0,0,0, add(7,9,11), 0, 7'b0100110,     3'b010, 2'b10,  7, 9, 8, 2'b00, 2'b00);
        row(0,0,0, add(7,9,11), 0, 7'b0100110,     3'b010, 2'b10,  7, 9, 8, 2'b00, 2'b00);
        row(0,1,0, nop(),       0, 7'b0100110,     3'b010, 2'b10,  7, 9, 8, 2'b00, 2'b00);
        row(0,1,0, nop(),       0, 7'h00,          3'b000, 2'b11,  0, 7, 9, 2'b00, 2'b00);
        row(0,1,0, nop(),       0, 7'h00,          3'b000, 2'b10,  0, 0, 7, 2'b00, 2'b00);
        // reset during a stall clears the hazard
        row(0,1,0, lw(2,9),     0, 7'h00,          3'b000, 2'b00,  0, 0, 0, 2'b00, 2'b00);
        row(1,1,0, add(9,10,11),1, 7'b0100000,     3'b000, 2'b00,  9, 0, 0, 2'b00, 2'b00);
        row(0,1,0, add(9,10,11),0, 7'h00,          3'b000, 2'b00,  0, 0, 0, 2'b00, 2'b00);
        row(0,1,0, nop(),       0, 7'b0000101,     3'b000, 2'b00, 11, 0, 0, 2'b00, 2'b00);
        row(0,1,0, nop(),       0, 7'h00,          3'b000, 2'b00,  0,11, 0, 2'b00, 2'b00);
        row(0,1,0, nop(),       0, 7'h00,          3'b000, 2'b10,  0, 0,11, 2'b00, 2'b00);
`ifdef CTRL_PIPE_FWD_EN
        // load-use: one stall, then MEM/WB forward to operand A
        row(0,1,0, lw(2,9),     0, 7'h00,          3'b000, 2'b00,  0, 0, 0, 2'b00, 2'b00);
        row(0,1,0, add(9,10,11),1, 7'b0100000,     3'b000, 2'b00,  9, 0, 0, 2'b00, 2'b00);
        row(0,1,0, add(9,10,11),0, 7'h00,          3'b010, 2'b00,  0, 9, 0, 2'b00, 2'b00);
        row(0,1,0, nop(),       0, 7'b0000101,     3'b000, 2'b11, 11, 0, 9, 2'b01, 2'b00);
        // both writers of $5 in flight: EX/MEM wins
        row(0,1,0, addi(5),     0, 7'h00,          3'b000, 2'b00,  0,11, 0, 2'b00, 2'b00);
        row(0,1,0, addi(5),     0, 7'b0100110,     3'b000, 2'b10,  5, 0,11, 2'b00, 2'b00);
        row(0,1,0, add(5,5,6),  0, 7'b0100110,     3'b000, 2'b00,  5, 5, 0, 2'b00, 2'b10);
        row(0,1,0, nop(),       0, 7'b0000101,     3'b000, 2'b10,  6, 5, 5, 2'b10, 2'b10);
        // only the older writer in MEM/WB
        row(0,1,0, addi(5),     0, 7'h00,          3'b000, 2'b10,  0, 6, 5, 2'b00, 2'b00);
        row(0,1,0, nop(),       0, 7'b0100110,     3'b000, 2'b10,  5, 0, 6, 2'b00, 2'b00);
        row(0,1,0, add(5,5,6),  0, 7'h00,          3'b000, 2'b00,  0, 5, 0, 2'b00, 2'b00);
        row(0,1,0, addi(0),     0, 7'b0000101,     3'b000, 2'b10,  6, 0, 5, 2'b01, 2'b01);
        // writer to $0 never forwards
        row(0,1,0, add(0,0,7),  0, 7'b0100110,     3'b000, 2'b00,  0, 6, 0, 2'b00, 2'b00);
        row(0,1,0, nop(),       0, 7'b0000101,     3'b000, 2'b10,  7, 0, 6, 2'b00, 2'b00);
`else
        // load followed by a reader: stalls until the load reaches MEM/WB
        row(0,1,0, lw(2,9),     0, 7'h00,          3'b000, 2'b00,  0, 0, 0, 2'b00, 2'b00);
        row(0,1,0, add(9,10,11),1, 7'b0100000,     3'b000, 2'b00,  9, 0, 0, 2'b00, 2'b00);
        row(0,1,0, add(9,10,11),1, 7'h00,          3'b010, 2'b00,  0, 9, 0, 2'b00, 2'b00);
        row(0,1,0, add(9,10,11),0, 7'h00,          3'b000, 2'b11,  0, 0, 9, 2'b00, 2'b00);
        row(0,1,0, nop(),       0, 7'b0000101,     3'b000, 2'b00, 11, 0, 0, 2'b00, 2'b00);
        // ADDI rt=3 then ADD rs=3: two stall cycles, no forwarding
        row(0,1,0, addi(3),     0, 7'h00,          3'b000, 2'b00,  0,11, 0, 2'b00, 2'b00);
        row(0,1,0, add(3,4,5),  1, 7'b0100110,     3'b000, 2'b10,  3, 0,11, 2'b00, 2'b00);
        row(0,1,0, add(3,4,5),  1, 7'h00,          3'b000, 2'b00,  0, 3, 0, 2'b00, 2'b00);
        row(0,1,0, add(3,4,5),  0, 7'h00,          3'b000, 2'b10,  0, 0, 3, 2'b00, 2'b00);
        row(0,1,0, nop(),       0, 7'b0000101,     3'b000, 2'b00,  5, 0, 0, 2'b00, 2'b00);
`endif

        // one reset edge before the table so state is defined
        drive(1, 1, 0, nop());
        @(posedge i_clk); #1;

        for (int k = 0; k < n_rows; k++) begin
            drive(vecs[k].rst, vecs[k].en, vecs[k].flush, vecs[k].ins);
            @(negedge i_clk);
            n_vec++;
            chk(k, "stall",    {6'b0, o_stall},      {6'b0, vecs[k].stall});
            chk(k, "ex_bus",   o_ex_bus,             vecs[k].ex);
            chk(k, "mem_bus",  {4'b0, o_ex_mem_bus}, {4'b0, vecs[k].mem});
            chk(k, "wb_bus",   {5'b0, o_wb_bus},     {5'b0, vecs[k].wb});
            chk(k, "ex_wreg",  {2'b0, o_ex_wreg},    {2'b0, vecs[k].ewr});
            chk(k, "mem_wreg", {2'b0, o_mem_wreg},   {2'b0, vecs[k].mwr});
            chk(k, "wb_wreg",  {2'b0, o_wb_wreg},    {2'b0, vecs[k].wwr});
            chk(k, "fwd_a",    {5'b0, o_fwd_a},      {5'b0, vecs[k].fa});
            chk(k, "fwd_b",    {5'b0, o_fwd_b},      {5'b0, vecs[k].fb});
            @(posedge i_clk); #1;
        end

        // stall-length measurement for a load followed by its reader
`ifdef CTRL_PIPE_FWD_EN
        exp_stalls = 2'd1; exp_fa = 2'b01;
`else
        exp_stalls = 2'd2; exp_fa = 2'b00;
`endif
        drive(1, 1, 0, nop());
        @(posedge i_clk); #1;
        drive(0, 1, 0, lw(4, 12));
        @(posedge i_clk); #1;
        drive(0, 1, 0, add(12, 13, 14));
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            if (o_stall) begin
                stalls++;
            end else begin
                done = 1'b1;
                break;
            end
            @(posedge i_clk); #1;
        end
        n_vec++;
        if (!done) begin
            $display("FAIL seq_stall_timeout: stall still high after %0d cycles, required release", stalls);
            n_miss++;
        end
        chk(n_rows, "seq_stall_len", stalls[6:0], exp_stalls[6:0]);
        @(posedge i_clk); #1;
        drive(0, 1, 0, nop());
        @(negedge i_clk);
        n_vec++;
        chk(n_rows + 1, "seq_ex_bus", o_ex_bus, 7'b0000101);
        chk(n_rows + 1, "seq_ex_wreg", {2'b0, o_ex_wreg}, 7'd14);
        chk(n_rows + 1, "seq_fwd_a", {5'b0, o_fwd_a}, {5'b0, exp_fa});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
